// File: rtl/pump_pkg.sv
// Shared types and helpers for the pump scheduler slice.
package pump_pkg;

    localparam logic [1:0] ENC_IDLE = 2'd0;
    localparam logic [1:0] ENC_LEAD = 2'd1;
    localparam logic [1:0] ENC_LAG  = 2'd2;
    localparam logic [1:0] ENC_BOTH = 2'd3;

    typedef enum logic [1:0] {
        IDLE = ENC_IDLE,
        LEAD = ENC_LEAD,
        LAG  = ENC_LAG,
        BOTH = ENC_BOTH
    } state_t;

    // Bits needed to hold 0..maxval, never less than one.
    function automatic int unsigned cnt_width(input int unsigned maxval);
        if (maxval < 1)
            return 1;
        return $clog2(maxval + 1);
    endfunction

endpackage

// File: rtl/pump_offtimer.sv
// Per-pump anti-short-cycle timer: loads MIN_OFF on pump switch-off, counts down to zero.
module pump_offtimer
    import pump_pkg::*;
#(
    parameter int unsigned MIN_OFF = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    output logic zero
);

    localparam int unsigned W = cnt_width(MIN_OFF);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (reset)
            count <= '0;
        else if (load)
            count <= W'(MIN_OFF);
        else if (count != '0)
            count <= count - 1'b1;
    end

    assign zero = (count == '0);

endmodule

// File: rtl/pump_scheduler.sv
// Two-pump lead/lag scheduler with fault failover, lead rotation and off-time lockout.
// Optional lead run-time swap is enabled by defining PUMP_RUNTIME_SWAP_EN.
module pump_scheduler
    import pump_pkg::*;
#(
    parameter int unsigned MIN_OFF = 4,
    parameter int unsigned MAX_RUN = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic req_one,
    input  logic req_two,
    input  logic fault1,
    input  logic fault2,
    output logic B1,
    output logic B2,
    output logic lead,
    output logic degraded,
    output logic alarm
);

    state_t     state, state_next;
    logic [1:0] want;
    logic       zero1, zero2;
    logic       ok1, ok2, ok_lead, ok_lag, fault_lag;
    logic       lead_next, b1_next, b2_next, b_lead, b_lag, deg_next;
    logic       swap;
    logic [1:0] n_on;

    assign ok1       = !fault1 && (B1 || zero1);
    assign ok2       = !fault2 && (B2 || zero2);
    assign ok_lead   = lead ? ok2 : ok1;
    assign ok_lag    = lead ? ok1 : ok2;
    assign fault_lag = lead ? fault1 : fault2;

    always_comb begin
        want = 2'd0;
        if (req_two)
            want = 2'd2;
        else if (req_one)
            want = 2'd1;

        state_next = IDLE;
        if (want == 2'd2 && ok_lead && ok_lag)
            state_next = BOTH;
        else if (want != 2'd0) begin
            if (ok_lead)
                state_next = LEAD;
            else if (ok_lag)
                state_next = LAG;
        end
    end

`ifdef PUMP_RUNTIME_SWAP_EN
    localparam int unsigned RW = cnt_width(MAX_RUN);

    logic [RW-1:0] run_cnt, run_cnt_next;

    // At the limit the counter holds until the lag pump is able to take over.
    always_comb begin
        swap         = 1'b0;
        run_cnt_next = '0;
        if (state == LEAD) begin
            if (run_cnt == RW'(MAX_RUN - 1)) begin
                if (ok_lag && state_next == LEAD)
                    swap = 1'b1;
                else
                    run_cnt_next = run_cnt;
            end else begin
                run_cnt_next = run_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            run_cnt <= '0;
        else
            run_cnt <= run_cnt_next;
    end
`else
    assign swap = 1'b0;
`endif

    always_comb begin
        lead_next = lead;
        if (swap)
            lead_next = !lead;
        else if ((state == LEAD || state == BOTH) && state_next == IDLE && !fault_lag)
            lead_next = !lead;

        b_lead = 1'b0;
        b_lag  = 1'b0;
        case (state_next)
            LEAD:    b_lead = 1'b1;
            LAG:     b_lag  = 1'b1;
            BOTH: begin
                b_lead = 1'b1;
                b_lag  = 1'b1;
            end
            default: ;
        endcase

        b1_next  = lead_next ? b_lag  : b_lead;
        b2_next  = lead_next ? b_lead : b_lag;
        n_on     = {1'b0, b1_next} + {1'b0, b2_next};
        deg_next = (want != 2'd0) && (n_on < want);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            lead     <= 1'b0;
            B1       <= 1'b0;
            B2       <= 1'b0;
            degraded <= 1'b0;
            alarm    <= 1'b0;
        end else begin
            state    <= state_next;
            lead     <= lead_next;
            B1       <= b1_next;
            B2       <= b2_next;
            degraded <= deg_next;
            alarm    <= fault1 && fault2;
        end
    end

    pump_offtimer #(.MIN_OFF(MIN_OFF)) u_off1 (
        .clk   (clk),
        .reset (reset),
        .load  (B1 && !b1_next),
        .zero  (zero1)
    );

    pump_offtimer #(.MIN_OFF(MIN_OFF)) u_off2 (
        .clk   (clk),
        .reset (reset),
        .load  (B2 && !b2_next),
        .zero  (zero2)
    );

endmodule

// File: tb/tb_pump_scheduler.sv
// Self-checking bench for pump_scheduler: directed scenarios plus random traffic against a pump-level model.
module tb_pump_scheduler;

    localparam int unsigned MIN_OFF = 4;
    localparam int unsigned MAX_RUN = 16;

    logic clk = 1'b0;
    logic reset, req_one, req_two, fault1, fault2;
    logic B1, B2, lead, degraded, alarm;

    always #5 clk = ~clk;

    pump_scheduler #(.MIN_OFF(MIN_OFF), .MAX_RUN(MAX_RUN)) dut (
        .clk      (clk),
        .reset    (reset),
        .req_one  (req_one),
        .req_two  (req_two),
        .fault1   (fault1),
        .fault2   (fault2),
        .B1       (B1),
        .B2       (B2),
        .lead     (lead),
        .degraded (degraded),
        .alarm    (alarm)
    );

    int total = 0;
    int bad   = 0;

    // Model: which physical pumps run, their lockout countdowns, and the lead index.
    bit m_on [2];
    int m_tmr[2];
    int m_lead;
    bit m_deg, m_alarm;
    int m_run;

    task automatic check(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: got %b expected %b", tag, obs, exp);
        end
    endtask

    function automatic void model_step();
        bit f[2];
        bit ok[2];
        bit nxt[2];
        int w, L, G;
        bit swap;
        f[0] = fault1;
        f[1] = fault2;
        if (reset) begin
            m_on = '{0, 0};
            m_tmr = '{0, 0};
            m_lead = 0;
            m_deg = 0;
            m_alarm = 0;
            m_run = 0;
            return;
        end
        w = req_two ? 2 : (req_one ? 1 : 0);
        for (int k = 0; k < 2; k++)
            ok[k] = !f[k] && (m_on[k] || m_tmr[k] == 0);
        L = m_lead;
        G = 1 - L;
        nxt = '{0, 0};
        if (w == 2 && ok[L] && ok[G]) begin
            nxt[L] = 1;
            nxt[G] = 1;
        end else if (w > 0) begin
            if (ok[L])
                nxt[L] = 1;
            else if (ok[G])
                nxt[G] = 1;
        end
        swap = 0;
`ifdef PUMP_RUNTIME_SWAP_EN
        begin
            bit solo_now, solo_next;
            solo_now  = m_on[L] && !m_on[G];
            solo_next = nxt[L] && !nxt[G];
            if (solo_now && solo_next && m_run == int'(MAX_RUN) - 1 && ok[G]) begin
                swap = 1;
                nxt[L] = 0;
                nxt[G] = 1;
                m_run = 0;
            end else if (solo_now)
                m_run = (m_run == int'(MAX_RUN) - 1) ? m_run : m_run + 1;
            else
                m_run = 0;
        end
`endif
        if (swap)
            m_lead = G;
        else if (m_on[L] && !nxt[0] && !nxt[1] && !f[G])
            m_lead = G;
        for (int k = 0; k < 2; k++) begin
            if (m_on[k] && !nxt[k])
                m_tmr[k] = MIN_OFF;
            else if (m_tmr[k] > 0)
                m_tmr[k]--;
        end
        m_deg = (w > 0) && ((int'(nxt[0]) + int'(nxt[1])) < w);
        m_alarm = f[0] && f[1];
        m_on = nxt;
    endfunction

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        check("B1", B1, m_on[0]);
        check("B2", B2, m_on[1]);
        check("lead", lead, m_lead[0]);
        check("degraded", degraded, m_deg);
        check("alarm", alarm, m_alarm);
    endtask

    task automatic drive(input logic rst, input logic r1, input logic r2,
                         input logic f1, input logic f2, input int n);
        for (int i = 0; i < n; i++) begin
            reset = rst; req_one = r1; req_two = r2; fault1 = f1; fault2 = f2;
            cycle();
        end
    endtask

    initial begin
        reset = 1'b1; req_one = 1'b0; req_two = 1'b0; fault1 = 1'b0; fault2 = 1'b0;
        drive(1, 0, 0, 0, 0, 2);
        check("reset_B1", B1, 1'b0);
        check("reset_lead", lead, 1'b0);

        // First fill cycle on pump 1, then rotation hands the lead to pump 2.
        drive(0, 1, 0, 0, 0, 1);
        check("first_run_B1", B1, 1'b1);
        check("first_run_B2", B2, 1'b0);
        drive(0, 1, 0, 0, 0, 4);
        drive(0, 0, 0, 0, 0, 1);
        check("release_B1", B1, 1'b0);
        check("release_lead", lead, 1'b1);
        drive(0, 1, 0, 0, 0, 1);
        check("rotated_B2", B2, 1'b1);
        drive(0, 1, 0, 0, 0, 2);

        // Short gaps between runs exercise the lockout path.
        drive(0, 0, 0, 0, 0, 1);
        drive(0, 1, 0, 0, 0, 3);
        drive(0, 0, 0, 0, 0, 1);
        drive(0, 1, 0, 0, 0, 3);
        drive(0, 0, 0, 0, 0, 1);
        drive(0, 1, 0, 0, 0, 3);
        drive(0, 0, 0, 0, 0, 8);

        // Two-pump demand with fault on pump 2 and recovery.
        drive(0, 0, 1, 0, 0, 3);
        drive(0, 0, 1, 0, 1, 2);
        drive(0, 0, 1, 0, 0, 8);
        drive(0, 0, 0, 0, 0, 8);

        // Double fault, then clear fault 1.
        drive(0, 1, 0, 1, 1, 3);
        check("double_fault_alarm", alarm, 1'b1);
        drive(0, 1, 0, 0, 1, 3);
        check("single_fault_alarm", alarm, 1'b0);
        drive(0, 0, 0, 0, 0, 8);

        // Long single-pump run for the run-time swap option.
        drive(0, 1, 0, 0, 0, 40);
        drive(0, 0, 0, 0, 0, 6);

        // Reset in the middle of a two-pump run.
        drive(0, 0, 1, 0, 0, 3);
        drive(1, 0, 1, 0, 0, 1);
        check("midrun_reset_B1", B1, 1'b0);
        check("midrun_reset_B2", B2, 1'b0);
        check("midrun_reset_lead", lead, 1'b0);
        drive(0, 1, 0, 0, 0, 1);
        check("post_reset_B1", B1, 1'b1);
        drive(0, 1, 0, 0, 0, 2);

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            logic rst, r1, r2, f1, f2;
            rst = ($urandom_range(0, 79) == 0);
            r1  = ($urandom_range(0, 3) != 0);
            r2  = ($urandom_range(0, 3) == 0);
            f1  = ($urandom_range(0, 9) == 0);
            f2  = ($urandom_range(0, 9) == 0);
            drive(rst, r1, r2, f1, f2, $urandom_range(1, 6));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
